// File: rtl/krnl_ctrl_pkg.sv
// Shared constants, types and helpers for the kernel control
// register file and its argument registers.
package krnl_ctrl_pkg;

  localparam logic [31:0] ADDR_CTRL     = 32'h00;
  localparam logic [31:0] ADDR_GIE      = 32'h04;
  localparam logic [31:0] ADDR_IER      = 32'h08;
  localparam logic [31:0] ADDR_ISR      = 32'h0C;
  localparam logic [31:0] ADDR_ARG_BASE = 32'h10;
  localparam logic [31:0] ARG_STRIDE    = 32'd8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIDLE,
    WDATA,
    WRESP
  } wstate_t;

  typedef enum logic {
    RIDLE,
    RDATA
  } rstate_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/krnl_ctrl_s_axi_param_arg_reg.sv
// One 32-bit kernel argument word with byte-strobed writes.
// Holds its value whenever aclken is low.
module krnl_ctrl_arg_reg
  import krnl_ctrl_pkg::*;
(
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        aclken,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] q
);

  logic [31:0] mask;

  assign mask = strb_to_mask(wstrb);

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      q <= '0;
    end else if (aclken && we) begin
      q <= (wdata & mask) | (q & ~mask);
    end
  end

endmodule

// File: rtl/krnl_ctrl_s_axi_param.sv
// AXI4-Lite control/status slave for RTL kernels: handshake,
// interrupts and a regular map of 32/64-bit kernel arguments.
module krnl_ctrl_s_axi_param #(
  parameter int          C_ADDR_WIDTH = 8,
  parameter int          NUM_ARGS     = 8,
  parameter logic [15:0] ARG64_MASK   = 16'h0049,
  parameter bit          ENABLE_CHAIN = 1'b1
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    aclken,
  input  logic [C_ADDR_WIDTH-1:0] AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [31:0]             WDATA,
  input  logic [3:0]              WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [C_ADDR_WIDTH-1:0] ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [31:0]             RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    ap_start,
  input  logic                    ap_done,
  input  logic                    ap_idle,
  input  logic                    ap_ready,
  output logic                    ap_continue,
  output logic [64*NUM_ARGS-1:0]  args,
  output logic                    interrupt
);

  import krnl_ctrl_pkg::*;

  localparam int WIW = $clog2(2 * NUM_ARGS);

  function automatic logic is_mapped(input logic [C_ADDR_WIDTH-1:0] a);
    logic [31:0] off;
    logic [31:0] idx;
    off = 32'(a);
    idx = (off - ADDR_ARG_BASE) / ARG_STRIDE;
    if (off[1:0] != 2'b00) return 1'b0;
    if (off < ADDR_ARG_BASE) return 1'b1;
    if (idx >= 32'(NUM_ARGS)) return 1'b0;
    if (off[2]) return ARG64_MASK[idx[3:0]];
    return 1'b1;
  endfunction

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic [C_ADDR_WIDTH-1:0] waddr;
  logic [31:0] woff, roff;
  logic aw_hs, w_hs, ar_hs;
  logic wr_en, rd_map;
  logic ctrl_we, gie_we, ier_we, isr_we, ctrl_rd;
  logic done, auto_restart, gie;
  logic [1:0] ier, isr, isr_set, isr_tgl;
  logic [31:0] rd_val;
  logic [WIW-1:0] widx;
  logic [31:0] arg_words [2*NUM_ARGS];

  assign aw_hs = aclken & AWVALID & AWREADY;
  assign w_hs  = aclken & WVALID & WREADY;
  assign ar_hs = aclken & ARVALID & ARREADY;

  assign woff  = 32'(waddr);
  assign wr_en = w_hs & is_mapped(waddr);

  assign ctrl_we = wr_en & (woff == ADDR_CTRL) & WSTRB[0];
  assign gie_we  = wr_en & (woff == ADDR_GIE) & WSTRB[0];
  assign ier_we  = wr_en & (woff == ADDR_IER) & WSTRB[0];
  assign isr_we  = wr_en & (woff == ADDR_ISR) & WSTRB[0];

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wstate <= WIDLE;
    end else if (aclken) begin
      wstate <= wnext;
    end
  end

  always_comb begin
    wnext = wstate;
    unique case (wstate)
      WIDLE:               if (AWVALID) wnext = krnl_ctrl_pkg::WDATA;
      krnl_ctrl_pkg::WDATA: if (WVALID) wnext = WRESP;
      WRESP:               if (BREADY) wnext = WIDLE;
      default:             wnext = WIDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    unique case (wstate)
      WIDLE:               AWREADY = areset_n;
      krnl_ctrl_pkg::WDATA: WREADY = 1'b1;
      WRESP: begin
        BVALID = 1'b1;
        BRESP  = is_mapped(waddr) ? RESP_OKAY : RESP_SLVERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      waddr <= '0;
    end else if (aw_hs) begin
      waddr <= AWADDR;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rstate <= RIDLE;
    end else if (aclken) begin
      rstate <= rnext;
    end
  end

  always_comb begin
    rnext = rstate;
    unique case (rstate)
      RIDLE:               if (ARVALID) rnext = krnl_ctrl_pkg::RDATA;
      krnl_ctrl_pkg::RDATA: if (RREADY) rnext = RIDLE;
      default:             rnext = RIDLE;
    endcase
  end

  always_comb begin
    ARREADY = (rstate == RIDLE) & areset_n;
    RVALID  = (rstate == krnl_ctrl_pkg::RDATA);
  end

  for (genvar j = 0; j < 2 * NUM_ARGS; j++) begin : g_word
    assign arg_words[j] = args[32*j +: 32];
  end

  assign roff    = 32'(ARADDR);
  assign rd_map  = is_mapped(ARADDR);
  assign widx    = WIW'((roff - ADDR_ARG_BASE) >> 2);
  assign ctrl_rd = ar_hs & (roff == ADDR_CTRL);

  always_comb begin
    rd_val = '0;
    if (rd_map) begin
      unique case (1'b1)
        roff == ADDR_CTRL: rd_val = {24'd0, auto_restart, 2'b00,
                                     ap_continue, ap_ready, ap_idle,
                                     done, ap_start};
        roff == ADDR_GIE:  rd_val = {31'd0, gie};
        roff == ADDR_IER:  rd_val = {30'd0, ier};
        roff == ADDR_ISR:  rd_val = {30'd0, isr};
        default:           rd_val = arg_words[widx];
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      RDATA <= rd_val;
      RRESP <= rd_map ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // A same-cycle interrupt event overrides the host's toggle.
  assign isr_set = ier & {ap_ready, ap_done};
  assign isr_tgl = isr_we ? WDATA[1:0] : 2'b00;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done         <= 1'b0;
      ap_continue  <= 1'b0;
      gie          <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
    end else if (aclken) begin
      if (ctrl_we && WDATA[0]) begin
        ap_start <= 1'b1;
      end else if (ap_ready) begin
        ap_start <= auto_restart;
      end
      if (ctrl_we) auto_restart <= WDATA[7];
      if (ap_done) begin
        done <= 1'b1;
      end else if (ctrl_rd) begin
        done <= 1'b0;
      end
      ap_continue <= ENABLE_CHAIN &&
                     ((ctrl_we && WDATA[4]) || (ap_done && auto_restart));
      if (gie_we) gie <= WDATA[0];
      if (ier_we) ier <= WDATA[1:0];
      isr <= isr_set | (isr ^ isr_tgl);
    end
  end

  assign interrupt = gie & (isr[0] | isr[1]);

  for (genvar i = 0; i < NUM_ARGS; i++) begin : g_arg
    localparam logic [31:0] LO = ADDR_ARG_BASE + ARG_STRIDE * i;

    krnl_ctrl_arg_reg u_lo (
      .aclk     (aclk),
      .areset_n (areset_n),
      .aclken   (aclken),
      .we       (wr_en && (woff == LO)),
      .wdata    (WDATA),
      .wstrb    (WSTRB),
      .q        (args[64*i +: 32])
    );

    if (ARG64_MASK[i]) begin : g_hi
      krnl_ctrl_arg_reg u_hi (
        .aclk     (aclk),
        .areset_n (areset_n),
        .aclken   (aclken),
        .we       (wr_en && (woff == LO + 32'd4)),
        .wdata    (WDATA),
        .wstrb    (WSTRB),
        .q        (args[64*i+32 +: 32])
      );
    end else begin : g_nohi
      assign args[64*i+32 +: 32] = '0;
    end
  end

endmodule

// File: doc/krnl_ctrl_s_axi_param.md
Name: krnl_ctrl_s_axi_param

Overview:
- Parametrised AXI4-Lite slave control/status register file for RTL kernels.
- Provides ap_ctrl_hs or ap_ctrl_chain handshake, interrupt logic, and NUM_ARGS scalar/pointer arguments on a regular address map.
- Adds per-argument 32/64-bit width selection, byte-strobed writes, SLVERR on unmapped accesses, and an ap_continue pulse.
- Sits between the host shell's control AXI4-Lite port and the kernel datapath top.

Parameters:
- C_ADDR_WIDTH, 8, AXI-Lite address bits decoded; must satisfy 2^C_ADDR_WIDTH > 0x10 + 8*NUM_ARGS.
- NUM_ARGS, 8, number of kernel arguments (1..16).
- ARG64_MASK, 16'h0049, bit i = 1 makes arg i 64-bit (pointer); otherwise 32-bit.
- ENABLE_CHAIN, 1, 1 = ap_ctrl_chain (ap_continue implemented); 0 = ap_ctrl_hs (bit 4 reads 0, writes ignored).

Ports:
- aclk  in  1  clock.
- areset_n  in  1  synchronous active-low reset.
- aclken  in  1  clock enable; all state holds when 0.
- AWADDR in C_ADDR_WIDTH; AWVALID in 1; AWREADY out 1.
- WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1.
- BRESP out 2; BVALID out 1; BREADY in 1.
- ARADDR in C_ADDR_WIDTH; ARVALID in 1; ARREADY out 1.
- RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1.
- ap_start out 1; ap_done in 1; ap_idle in 1; ap_ready in 1; ap_continue out 1.
- args  out  64*NUM_ARGS  arg i at bits [64i+63:64i]; the upper half is tied to 0 for 32-bit args.
- interrupt  out  1  level interrupt to host.

Behaviour:
- Address map:
  - 0x00 CTRL: b0 start, b1 done, b2 idle, b3 ready, b4 continue, b7 auto_restart.
  - 0x04 GIE b0.
  - 0x08 IER b1:0.
  - 0x0C ISR b1:0.
  - Arg i: low word at 0x10+8i; high word at 0x14+8i only if ARG64_MASK[i].
  - Any other offset (incl. unaligned, high word of a 32-bit arg) is unmapped.
- Reset (areset_n=0 at posedge): write/read FSMs to IDLE, all registers 0. Outputs: AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RDATA=0, ap_start=0, ap_continue=0, interrupt=0, args=0.
- In-flight transactions are dropped at reset; no response is issued.
- AWREADY/ARREADY are additionally gated low while areset_n=0.
- Write FSM, states WIDLE -> WDATA -> WRESP:
  - WIDLE: AWREADY=1; on AW handshake latch AWADDR -> WDATA.
  - WDATA: WREADY=1; on W handshake apply write -> WRESP.
  - WRESP: BVALID=1; BRESP=2'b00 if the latched address is mapped, else 2'b10; hold until BREADY -> WIDLE.
  - Minimum write = 3 cycles.
- Read FSM, states RIDLE -> RDATA:
  - RIDLE: ARREADY=1; on AR handshake register RDATA/RRESP -> RDATA.
  - RDATA: RVALID=1; RDATA/RRESP stable until RREADY.
  - Unmapped read returns RDATA=0, RRESP=2'b10.
  - Read and write paths are independent and may be concurrent.
- Arg registers: new = (WDATA & mask) | (old & ~mask), mask built from WSTRB bytes. An unmapped write alters nothing.
- ap_start:
  - Set by a CTRL write with WSTRB[0]&WDATA[0].
  - Otherwise, on ap_ready, reload from auto_restart.
  - Host write-set wins over a same-cycle ap_ready.
- done: sticky; set by ap_done; cleared by a CTRL read handshake. ap_done in the same cycle as the clearing read leaves done=1, and that read returns the pre-update value.
- ap_continue (ENABLE_CHAIN=1): a one-cycle pulse on the cycle after a CTRL write with WSTRB[0]&WDATA[4]. Also pulses automatically on the cycle after ap_done when auto_restart=1.
- idle/ready read live inputs.
- ISR[0]: set by ier[0]&ap_done; ISR[1]: set by ier[1]&ap_ready. A write of 1 toggles the bit. A same-cycle set wins over the toggle.
- interrupt = gie & (isr[0]|isr[1]), registered-free combinational from flops.
- aclken=0: FSMs, registers and the ap_continue pulse generator all freeze. Ready/valid outputs still reflect the frozen state.

Decomposition:
- Shared package krnl_ctrl_pkg:
  - Offsets ADDR_CTRL/GIE/IER/ISR/ARG_BASE, ARG_STRIDE=8.
  - Constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Enums wstate_t {WIDLE,WDATA,WRESP} and rstate_t {RIDLE,RDATA}.
  - Function strb_to_mask(4b)->32b.
- Sub-module krnl_ctrl_arg_reg: one 32-bit byte-strobed register with write-enable, reset and aclken. Instantiated via generate once per arg word present.

Test Plan:
- Reset then write 0xDEADBEEF to 0x10 with WSTRB=4'b0101 -> args[31:0]=0x00AD00EF, BRESP=00. Readback returns same value, RRESP=00.
- Write 0x1234 to 0x1C (high word of 32-bit arg 1 with default mask) -> BRESP=10, args unchanged. Read 0x1C -> RDATA=0, RRESP=10.
- Write CTRL=0x01, then pulse ap_ready -> ap_start 1 then 0. With CTRL=0x81, after ap_ready -> ap_start stays 1.
- GIE=1, IER=01, pulse ap_done -> interrupt=1 and CTRL read shows b1=1. Second CTRL read shows b1=0. Write ISR=01 -> interrupt=0.
- ap_done in the same cycle as a CTRL AR handshake -> done remains 1 on the next read.
- ENABLE_CHAIN=1: write CTRL=0x10 -> ap_continue high for exactly 1 cycle. Reset asserted while BVALID=1 and RREADY=0 -> BVALID/RVALID=0 next cycle, all args=0.
